// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer
// Ping-pong reorder buffer for the streaming FFT datapath. Each N-point frame
// fills one bank. Frames are written at bit-reversed addresses in reorder
// mode, or at natural addresses in bypass mode. The other bank is read back
// in natural address order, so the output always comes out in natural order.

module fft_reorder_buffer #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     in_push,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     in_stall,
  output logic                     out_push,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     out_last,
  input  logic                     out_stall,
  output logic [15:0]              frame_cnt
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] IDX_ZERO = {LOG2_N{1'b0}};
  localparam logic [LOG2_N-1:0] IDX_LAST = {LOG2_N{1'b1}};
  localparam logic [LOG2_N-1:0] IDX_ONE  = LOG2_N'(1);

  // Reverse the LOG2_N-bit index field.
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] k);
    logic [LOG2_N-1:0] r;
    r = IDX_ZERO;
    for (int i = 0; i < LOG2_N; i++) begin
      r[i] = k[LOG2_N-1-i];
    end
    return r;
  endfunction

  // Sample storage, one array per bank; contents need no reset.
  logic [2*DATA_W-1:0] mem0 [N];
  logic [2*DATA_W-1:0] mem1 [N];

  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [LOG2_N-1:0] wr_idx_r;
  logic [LOG2_N-1:0] rd_idx_r;
  logic [1:0]        full_r;
  logic [1:0]        mode_lat_r;
  logic [15:0]       frame_cnt_r;

  logic                     out_push_r;
  logic                     out_last_r;
  logic signed [DATA_W-1:0] out_real_r;
  logic signed [DATA_W-1:0] out_imag_r;

  logic                accept_s;
  logic                load_s;
  logic                wr_mode_s;
  logic [LOG2_N-1:0]   wr_addr_s;
  logic [2*DATA_W-1:0] rd_data_s;

  // Stall depends only on registered bank state, never on in_push or out_stall.
  assign in_stall  = full_r[wr_bank_r];
  assign accept_s  = in_push & ~full_r[wr_bank_r];
  assign load_s    = full_r[rd_bank_r] & (~out_push_r | ~out_stall);

  assign out_push  = out_push_r;
  assign out_last  = out_last_r;
  assign out_real  = out_real_r;
  assign out_imag  = out_imag_r;
  assign frame_cnt = frame_cnt_r;

  // Write address: sample 0 uses the live mode pin, the rest use the latched bit.
  always_comb begin
    wr_mode_s = 1'b0;
    wr_addr_s = IDX_ZERO;
    if (wr_idx_r == IDX_ZERO) begin
      wr_mode_s = mode;
    end else begin
      wr_mode_s = mode_lat_r[wr_bank_r];
    end
    if (wr_mode_s) begin
      wr_addr_s = wr_idx_r;
    end else begin
      wr_addr_s = bitrev(wr_idx_r);
    end
  end

  // Read mux: natural-order read from the current read bank.
  always_comb begin
    rd_data_s = {(2*DATA_W){1'b0}};
    if (rd_bank_r) begin
      rd_data_s = mem1[rd_idx_r];
    end else begin
      rd_data_s = mem0[rd_idx_r];
    end
  end

  // Bank storage write on every accepted sample.
  always_ff @(posedge clk) begin
    if (accept_s && !reset) begin
      if (wr_bank_r) begin
        mem1[wr_addr_s] <= {in_real, in_imag};
      end else begin
        mem0[wr_addr_s] <= {in_real, in_imag};
      end
    end
  end

  // Write/read pointers, per-bank full flags, latched modes and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_idx_r    <= IDX_ZERO;
      rd_idx_r    <= IDX_ZERO;
      full_r      <= 2'b00;
      mode_lat_r  <= 2'b00;
      frame_cnt_r <= 16'd0;
    end else begin
      if (accept_s) begin
        if (wr_idx_r == IDX_ZERO) begin
          mode_lat_r[wr_bank_r] <= mode;
        end
        if (wr_idx_r == IDX_LAST) begin
          full_r[wr_bank_r] <= 1'b1;
          wr_bank_r         <= ~wr_bank_r;
          wr_idx_r          <= IDX_ZERO;
        end else begin
          wr_idx_r <= wr_idx_r + IDX_ONE;
        end
      end
      // The bank being cleared is never the bank being set on the same edge.
      if (load_s) begin
        if (rd_idx_r == IDX_LAST) begin
          full_r[rd_bank_r] <= 1'b0;
          rd_bank_r         <= ~rd_bank_r;
          rd_idx_r          <= IDX_ZERO;
          frame_cnt_r       <= frame_cnt_r + 16'd1;
        end else begin
          rd_idx_r <= rd_idx_r + IDX_ONE;
        end
      end
    end
  end

  // Output register: load when the slot is free or draining, hold under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_push_r <= 1'b0;
      out_last_r <= 1'b0;
      out_real_r <= {DATA_W{1'b0}};
      out_imag_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      out_push_r <= 1'b1;
      out_last_r <= (rd_idx_r == IDX_LAST);
      out_real_r <= rd_data_s[2*DATA_W-1:DATA_W];
      out_imag_r <= rd_data_s[DATA_W-1:0];
    end else if (!out_stall) begin
      out_push_r <= 1'b0;
      out_last_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed testbench for fft_reorder_buffer (DATA_W=16, N=16).
module tb_fft_reorder_buffer;

  logic               clk;
  logic               reset;
  logic               mode;
  logic               in_push;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               in_stall;
  logic               out_push;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic               out_last;
  logic               out_stall;
  logic [15:0]        frame_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Bit-reversed order of 0..15, written out by hand.
  int br16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_reorder_buffer #(.DATA_W(16), .LOG2_N(4)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_push(in_push), .in_real(in_real), .in_imag(in_imag), .in_stall(in_stall),
    .out_push(out_push), .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .out_stall(out_stall), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mode = 1'b0; in_push = 1'b0; out_stall = 1'b0;
    in_real = 16'sd0; in_imag = 16'sd0;
    tick; tick;
    vec_cnt++;
    if (out_push !== 1'b0 || out_last !== 1'b0 || out_real !== 16'sd0 ||
        out_imag !== 16'sd0 || frame_cnt !== 16'd0) begin
      $display("FAIL reset_outputs: got push=%b last=%b re=%h im=%h cnt=%0d, expected all 0",
               out_push, out_last, out_real, out_imag, frame_cnt);
      err_cnt++;
    end
    reset = 1'b0;
    tick;
    vec_cnt++;
    if (in_stall !== 1'b0) begin
      $display("FAIL reset_in_stall: got %b expected 0", in_stall);
      err_cnt++;
    end
  endtask

  task automatic test_reorder;
    logic signed [15:0] er, ei;
    mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_push = 1'b1; in_real = 16'(k); in_imag = -16'(k);
      vec_cnt++;
      if (in_stall !== 1'b0) begin
        $display("FAIL reorder_in_stall k=%0d: got %b expected 0", k, in_stall);
        err_cnt++;
      end
      tick;
    end
    in_push = 1'b0;
    vec_cnt++;
    if (out_push !== 1'b0) begin
      $display("FAIL reorder_latency: got out_push=%b expected 0 at last accept", out_push);
      err_cnt++;
    end
    for (int j = 0; j < 16; j++) begin
      tick;
      er = 16'(br16[j]); ei = -er;
      vec_cnt++;
      if (out_push !== 1'b1 || out_real !== er || out_imag !== ei || out_last !== (j == 15)) begin
        $display("FAIL reorder_out j=%0d: got push=%b re=%h im=%h last=%b expected 1 %h %h %b",
                 j, out_push, out_real, out_imag, out_last, er, ei, (j == 15));
        err_cnt++;
      end
    end
    tick;
    vec_cnt++;
    if (out_push !== 1'b0 || frame_cnt !== 16'd1) begin
      $display("FAIL reorder_end: got push=%b cnt=%0d expected 0 1", out_push, frame_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_bypass;
    logic signed [15:0] ev;
    // mode drops after sample 0; the latched bypass mode must still apply.
    for (int k = 0; k < 16; k++) begin
      mode = (k == 0);
      in_push = 1'b1;
      in_real = (k < 4) ? 16'sh4c00 : 16'sd0;
      in_imag = (k < 4) ? 16'sh4c00 : 16'sd0;
      vec_cnt++;
      if (in_stall !== 1'b0) begin
        $display("FAIL bypass_in_stall k=%0d: got %b expected 0", k, in_stall);
        err_cnt++;
      end
      tick;
    end
    in_push = 1'b0; mode = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick;
      ev = (j < 4) ? 16'sh4c00 : 16'sd0;
      vec_cnt++;
      if (out_push !== 1'b1 || out_real !== ev || out_imag !== ev || out_last !== (j == 15)) begin
        $display("FAIL bypass_out j=%0d: got push=%b re=%h im=%h last=%b expected 1 %h %h %b",
                 j, out_push, out_real, out_imag, out_last, ev, ev, (j == 15));
        err_cnt++;
      end
    end
    tick;
    vec_cnt++;
    if (out_push !== 1'b0 || frame_cnt !== 16'd2) begin
      $display("FAIL bypass_end: got push=%b cnt=%0d expected 0 2", out_push, frame_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] er;
    int o, f, j, src;
    out_stall = 1'b0;
    for (int t = 0; t < 80; t++) begin
      in_push = (t < 64);
      in_real = 16'(t);
      in_imag = ~16'(t);
      mode    = ((t / 16) % 2) == 1;
      if (t < 64) begin
        vec_cnt++;
        if (in_stall !== 1'b0) begin
          $display("FAIL b2b_in_stall t=%0d: got %b expected 0", t, in_stall);
          err_cnt++;
        end
      end
      tick;
      if (t < 16) begin
        vec_cnt++;
        if (out_push !== 1'b0) begin
          $display("FAIL b2b_early t=%0d: got out_push=%b expected 0", t, out_push);
          err_cnt++;
        end
      end else begin
        o = t - 16; f = o / 16; j = o % 16;
        src = (f % 2 == 1) ? j : br16[j];
        er = 16'(f * 16 + src);
        vec_cnt++;
        if (out_push !== 1'b1 || out_real !== er || out_imag !== ~er || out_last !== (j == 15)) begin
          $display("FAIL b2b_out o=%0d: got push=%b re=%h im=%h last=%b expected 1 %h %h %b",
                   o, out_push, out_real, out_imag, out_last, er, ~er, (j == 15));
          err_cnt++;
        end
      end
    end
    in_push = 1'b0; mode = 1'b0;
    tick;
    vec_cnt++;
    if (out_push !== 1'b0 || frame_cnt !== 16'd6) begin
      $display("FAIL b2b_end: got push=%b cnt=%0d expected 0 6", out_push, frame_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_toggle;
    logic signed [15:0] er, ei, pr, pi;
    logic pp, ps, pl;
    int k_in, got, cyc;
    k_in = 0; got = 0; cyc = 0;
    pp = 1'b0; ps = 1'b0; pl = 1'b0; pr = 16'sd0; pi = 16'sd0;
    mode = 1'b0;
    while (got < 16 && cyc < 100) begin
      if (pp && ps) begin
        vec_cnt++;
        if (out_push !== 1'b1 || out_real !== pr || out_imag !== pi || out_last !== pl) begin
          $display("FAIL toggle_hold cyc=%0d: got push=%b re=%h im=%h expected 1 %h %h",
                   cyc, out_push, out_real, out_imag, pr, pi);
          err_cnt++;
        end
      end
      in_push = (k_in < 16);
      in_real = 16'sh7000 + 16'(k_in);
      in_imag = 16'shf000 + 16'(k_in);
      out_stall = cyc[0];
      if (out_push && !out_stall) begin
        er = 16'sh7000 + 16'(br16[got]);
        ei = 16'shf000 + 16'(br16[got]);
        vec_cnt++;
        if (out_real !== er || out_imag !== ei || out_last !== (got == 15)) begin
          $display("FAIL toggle_out n=%0d: got re=%h im=%h last=%b expected %h %h %b",
                   got, out_real, out_imag, out_last, er, ei, (got == 15));
          err_cnt++;
        end
        got++;
      end
      pp = out_push; ps = out_stall; pl = out_last; pr = out_real; pi = out_imag;
      if (in_push && !in_stall) k_in++;
      tick;
      cyc++;
    end
    vec_cnt++;
    if (got != 16) begin
      $display("FAIL toggle_timeout: got %0d samples expected 16", got);
      err_cnt++;
    end
    in_push = 1'b0; out_stall = 1'b0;
    tick; tick;
    vec_cnt++;
    if (out_push !== 1'b0 || frame_cnt !== 16'd7) begin
      $display("FAIL toggle_end: got push=%b cnt=%0d expected 0 7", out_push, frame_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_stall_fill;
    int acc, got, cyc;
    logic saw, drop_seen;
    acc = 0; saw = 1'b0; mode = 1'b1; out_stall = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (in_stall) begin
        saw = 1'b1;
        break;
      end
      in_push = 1'b1;
      in_real = 16'sh0100 + 16'(acc);
      in_imag = 16'sh0200 + 16'(acc);
      tick;
      acc++;
    end
    vec_cnt++;
    if (!saw || acc != 32) begin
      $display("FAIL stall_fill_count: got stall=%b after %0d accepts expected 1 after 32", saw, acc);
      err_cnt++;
    end
    in_push = 1'b1; in_real = 16'shdead; in_imag = 16'shdead;
    tick; tick; tick;
    vec_cnt++;
    if (in_stall !== 1'b1 || out_push !== 1'b1 || out_real !== 16'sh0100 || out_imag !== 16'sh0200) begin
      $display("FAIL stall_fill_hold: got stall=%b push=%b re=%h im=%h expected 1 1 0100 0200",
               in_stall, out_push, out_real, out_imag);
      err_cnt++;
    end
    out_stall = 1'b0; got = 0; cyc = 0; drop_seen = 1'b0;
    while (got < 32 && cyc < 100) begin
      if (!drop_seen && !in_stall) begin
        drop_seen = 1'b1;
        vec_cnt++;
        if (got != 15) begin
          $display("FAIL stall_drop_point: got in_stall low after %0d outputs expected 15", got);
          err_cnt++;
        end
      end
      in_push = (acc < 40);
      in_real = 16'sh0100 + 16'(acc);
      in_imag = 16'sh0200 + 16'(acc);
      if (in_push && !in_stall) acc++;
      if (out_push) begin
        vec_cnt++;
        if (out_real !== 16'sh0100 + 16'(got) || out_imag !== 16'sh0200 + 16'(got) ||
            out_last !== (got % 16 == 15)) begin
          $display("FAIL stall_drain n=%0d: got re=%h im=%h last=%b expected %h %h %b", got,
                   out_real, out_imag, out_last, 16'sh0100 + 16'(got), 16'sh0200 + 16'(got),
                   (got % 16 == 15));
          err_cnt++;
        end
        got++;
      end
      tick;
      cyc++;
    end
    in_push = 1'b0;
    vec_cnt++;
    if (got != 32 || acc != 40) begin
      $display("FAIL stall_drain_total: got %0d outputs %0d accepts expected 32 40", got, acc);
      err_cnt++;
    end
    tick;
    vec_cnt++;
    if (out_push !== 1'b0 || frame_cnt !== 16'd9) begin
      $display("FAIL stall_end: got push=%b cnt=%0d expected 0 9", out_push, frame_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_reset_midframe;
    logic signed [15:0] er;
    mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_push = 1'b1; in_real = 16'sh1111; in_imag = 16'sh1111;
      tick;
    end
    reset = 1'b1;
    tick;
    vec_cnt++;
    if (out_push !== 1'b0 || out_last !== 1'b0 || out_real !== 16'sd0 ||
        out_imag !== 16'sd0 || frame_cnt !== 16'd0) begin
      $display("FAIL midreset_outputs: got push=%b last=%b re=%h im=%h cnt=%0d, expected all 0",
               out_push, out_last, out_real, out_imag, frame_cnt);
      err_cnt++;
    end
    reset = 1'b0; in_push = 1'b0;
    vec_cnt++;
    if (in_stall !== 1'b0) begin
      $display("FAIL midreset_in_stall: got %b expected 0", in_stall);
      err_cnt++;
    end
    for (int k = 0; k < 16; k++) begin
      in_push = 1'b1; in_real = 16'sh2000 + 16'(k); in_imag = 16'(k);
      tick;
    end
    in_push = 1'b0;
    vec_cnt++;
    if (out_push !== 1'b0) begin
      $display("FAIL midreset_residue: got out_push=%b expected 0", out_push);
      err_cnt++;
    end
    for (int j = 0; j < 16; j++) begin
      tick;
      er = 16'sh2000 + 16'(br16[j]);
      vec_cnt++;
      if (out_push !== 1'b1 || out_real !== er || out_imag !== 16'(br16[j]) ||
          out_last !== (j == 15)) begin
        $display("FAIL midreset_out j=%0d: got push=%b re=%h im=%h last=%b expected 1 %h %h %b",
                 j, out_push, out_real, out_imag, out_last, er, 16'(br16[j]), (j == 15));
        err_cnt++;
      end
    end
    tick;
    vec_cnt++;
    if (out_push !== 1'b0 || frame_cnt !== 16'd1) begin
      $display("FAIL midreset_end: got push=%b cnt=%0d expected 0 1", out_push, frame_cnt);
      err_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_reorder;
    test_bypass;
    test_back_to_back;
    test_toggle;
    test_stall_fill;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
